// File: rtl/tt_pkg.sv
// Shared definitions for the truth table scanner.
// State encoding and default settle time.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEFAULT_HOLD = 4;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle counter: counts enabled cycles from 0 and flags the last
// settle cycle (count == HOLD_CYCLES-1).
module settle_timer
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (r_cnt == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {a,b,c} through 0..7, lets the function under test settle,
// then captures w into an 8-bit truth table.
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       w,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] idx,
    output logic       busy,
    output logic       done,
    output logic [7:0] tbl
);

    state_e     r_state;
    logic [2:0] r_idx;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_tbl;

    logic w_expired;
    logic w_clr;
    logic w_en;

    assign w_clr = ((r_state == IDLE) && start) || (r_state == SAMPLE);
    assign w_en  = (r_state == DRIVE) && !w_expired;

    settle_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tbl   <= 8'h00;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= DRIVE;
                        r_idx   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_tbl   <= 8'h00;
                    end
                end
                DRIVE: begin
                    if (w_expired) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_tbl[r_idx] <= w;
                    // idx parks at 7 through DONE, never wraps
                    if (r_idx == 3'd7) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= DRIVE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c} = r_idx;
    assign idx       = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign tbl       = r_tbl;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: table of scan vectors plus reset/restart
// sequences, with a cycle-position model of the scan.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic w;
    logic sel;

    logic start4, start1;
    logic a4, b4, c4, busy4, done4;
    logic a1, b1, c1, busy1, done1;
    logic [2:0] idx4, idx1;
    logic [7:0] tbl4, tbl1;

    logic       o_a, o_b, o_c, o_busy, o_done;
    logic [2:0] o_idx;
    logic [7:0] o_tbl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign start4 = start & ~sel;
    assign start1 = start & sel;

    truth_table_scanner #(.HOLD_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .w     (w),
        .a     (a4),
        .b     (b4),
        .c     (c4),
        .idx   (idx4),
        .busy  (busy4),
        .done  (done4),
        .tbl   (tbl4)
    );

    truth_table_scanner #(.HOLD_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .w     (w),
        .a     (a1),
        .b     (b1),
        .c     (c1),
        .idx   (idx1),
        .busy  (busy1),
        .done  (done1),
        .tbl   (tbl1)
    );

    always_comb begin
        o_a    = sel ? a1    : a4;
        o_b    = sel ? b1    : b4;
        o_c    = sel ? c1    : c4;
        o_idx  = sel ? idx1  : idx4;
        o_busy = sel ? busy1 : busy4;
        o_done = sel ? done1 : done4;
        o_tbl  = sel ? tbl1  : tbl4;
    end

    typedef struct {
        string      nm;
        logic [7:0] fn;
        logic [7:0] exp;
        bit         noise;
        bit         poke;
        bit         h1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".abc"},  int'({o_a, o_b, o_c}), 0);
        chk({nm, ".idx"},  int'(o_idx), 0);
        chk({nm, ".busy"}, int'(o_busy), 0);
        chk({nm, ".done"}, int'(o_done), 0);
        chk({nm, ".tbl"},  int'(o_tbl), 0);
    endtask

    // Called at a negedge; cycle n is the n-th cycle after start is taken.
    task automatic scan(input vec_t v);
        int h;
        int total;
        int vi;
        int ph;
        int ev;
        int busy_cnt;
        logic [7:0] fn;
        h        = v.h1 ? 1 : 4;
        total    = 8 * (h + 1) + 1;
        busy_cnt = 0;
        fn       = v.fn;
        sel      = v.h1;
        start    = 1'b1;
        w        = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= total; n++) begin
            vi = (n - 1) / (h + 1);
            ph = (n - 1) % (h + 1);
            ev = (n == total) ? 7 : vi;
            chk({v.nm, ".idx"},  int'(o_idx), ev);
            chk({v.nm, ".abc"},  int'({o_a, o_b, o_c}), ev);
            chk({v.nm, ".busy"}, int'(o_busy), (n < total) ? 1 : 0);
            chk({v.nm, ".done"}, int'(o_done), (n == total) ? 1 : 0);
            if (o_busy) busy_cnt++;
            if (vi < 8) begin
                if (ph == h || !v.noise) w = fn[vi];
                else                     w = 1'($urandom);
            end
            start = v.poke && (n == 5 || n == total);
            @(negedge clk);
        end
        start = 1'b0;
        chk({v.nm, ".busycnt"}, busy_cnt, 8 * (h + 1));
        chk({v.nm, ".tbl"},  int'(o_tbl), int'(v.exp));
        chk({v.nm, ".idx_end"}, int'(o_idx), 7);
        for (int k = 0; k < 3; k++) begin
            w = 1'($urandom);
            @(negedge clk);
            chk({v.nm, ".hold_tbl"},  int'(o_tbl), int'(v.exp));
            chk({v.nm, ".hold_done"}, int'(o_done), 0);
            chk({v.nm, ".hold_busy"}, int'(o_busy), 0);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [7:0] fn,
                                input logic [7:0] exp, input bit noise,
                                input bit poke, input bit h1);
        vec_t v;
        v.nm = nm; v.fn = fn; v.exp = exp;
        v.noise = noise; v.poke = poke; v.h1 = h1;
        return v;
    endfunction

    initial begin
        logic [7:0] f_maj, f_and, f_xor, f_r;
        logic [2:0] ii;
        for (int i = 0; i < 8; i++) begin
            ii = i[2:0];
            f_maj[i] = ($countones(ii) >= 2);
            f_and[i] = (ii == 3'd7);
            f_xor[i] = $countones(ii) % 2 == 1;
        end
        vecs.push_back(mk("maj",      f_maj, 8'hE8, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("and3",     f_and, 8'h80, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("xor3",     f_xor, 8'h96, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("one_h1",   8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("maj_poke", f_maj, 8'hE8, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("maj_h1",   f_maj, 8'hE8, 1'b1, 1'b0, 1'b1));
        for (int r = 0; r < 4; r++) begin
            f_r = 8'($urandom);
            vecs.push_back(mk($sformatf("rnd%0d", r), f_r, f_r, 1'b1,
                              r[0], r[1]));
        end

        sel   = 1'b0;
        start = 1'b0;
        w     = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("rst4");
        sel = 1'b1;
        chk_zero("rst1");
        sel = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("idle4");

        foreach (vecs[i]) scan(vecs[i]);

        // Mid-scan reset discards the partial table
        sel   = 1'b0;
        w     = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n < 10; n++) @(negedge clk);
        chk("mid.tbl_partial", int'(o_tbl), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("midrst_idle");

        // Start in the first cycle after reset deasserts
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        scan(mk("post_rst", f_xor, 8'h96, 1'b1, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the settle cycles each input vector is driven before sampling (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic is clocked on its rising edge; single clock domain.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a scan.
REQ-005 SHALL have port w  input  1  output of the 3-input function under test.
REQ-006 SHALL have ports a, b, c  output  1 each  registered stimulus to the function under test; a is the MSB of the vector index, c the LSB.
REQ-007 SHALL have port idx  output  3  current vector index, where {a,b,c} == idx.
REQ-008 SHALL have port busy  output  1  high while a scan is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-010 SHALL have port table  output  8  captured truth table, where bit i = w sampled with {a,b,c} = i.

Function
REQ-011 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-012 In IDLE with start=1, SHALL go to DRIVE, set idx=0, clear the settle counter and clear table to 8'h00.
REQ-013 In IDLE with start=0, SHALL remain in IDLE and hold all outputs.
REQ-014 SHALL remain in DRIVE for exactly HOLD_CYCLES cycles, counting from 0 up to HOLD_CYCLES-1, with {a,b,c} stable at idx, then go to SAMPLE.
REQ-015 In SAMPLE (one cycle), SHALL write table[idx] <= w.
REQ-016 In SAMPLE with idx<7, SHALL increment idx, clear the counter and return to DRIVE.
REQ-017 In SAMPLE with idx==7, SHALL go to DONE and hold idx at 7; idx SHALL never wrap to 0 inside a scan.
REQ-018 In DONE, SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-019 SHALL drive busy=1 in DRIVE and SAMPLE only.
REQ-020 Each vector SHALL take HOLD_CYCLES+1 cycles, and done SHALL be high in cycle 8*(HOLD_CYCLES+1)+1 after the edge that captured start.
REQ-021 SHALL ignore start in DRIVE, SAMPLE and DONE; no restart and no queuing.
REQ-022 SHALL hold table stable from DONE until the next accepted start.
REQ-023 SHALL sample w only in SAMPLE; changes on w during DRIVE SHALL have no effect.
REQ-024 SHALL drive every output directly from a register, with no combinational path from any input to any output.
REQ-025 SHALL give the settle counter width $clog2(HOLD_CYCLES+1) bits.

Reset
REQ-026 When rst=1 at a rising edge, state SHALL become IDLE, and a=b=c=0, idx=0, counter=0, busy=0, done=0 and table=8'h00.
REQ-027 rst SHALL take priority over start and over every state transition, including mid-scan; a partial table SHALL be discarded.
REQ-028 If start=1 in the first cycle after rst deasserts, it SHALL be accepted normally.

Structure
REQ-029 The shared package tt_pkg SHALL hold the state encoding constants (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and DEFAULT_HOLD=4.
REQ-030 The settle counter SHALL be a sub-module settle_timer (inputs clk, rst, clr, en; output expired, high when the count equals HOLD_CYCLES-1).
REQ-031 The block SHALL instantiate the existing func1 module only in the bench, never inside the design.

Verification
REQ-032 With w fed by a 3-input majority function and HOLD_CYCLES=4, pulse start -> done in cycle 41, then table=8'hE8 and idx=7.
REQ-033 With w = a&b&c -> table=8'h80; with w = a^b^c -> table=8'h96.
REQ-034 With w tied to 1 and HOLD_CYCLES=1 -> done in cycle 17, table=8'hFF, and busy high for exactly 16 cycles.
REQ-035 Assert rst at cycle 10 of a scan -> next cycle all outputs are zero and state is IDLE; a new start then yields a correct table.
REQ-036 Pulse start again at cycle 5 and during DONE -> the pulses are ignored, exactly one done pulse occurs, and the table is unaffected.
REQ-037 Toggle w during DRIVE while holding it correct at SAMPLE -> table matches the correct function value.
